// File: rtl/hazard_stall_ctrl.sv
// D-stage interlock: compares D source operands against E/M destinations and
// their remaining produce latency, and holds HI/LO users while mult/div is busy.
module hazard_stall_ctrl #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_j,
    input  logic       d_r,
    input  logic       d_i,
    input  logic       d_ld,
    input  logic       d_st,
    input  logic       d_jal,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_rd,
    input  logic       clr,
    output logic       stall,
    output logic       stall_reg,
    output logic       stall_md,
    output logic       md_busy,
    output logic [4:0] dst_e,
    output logic [4:0] dst_m
);

    localparam int MAX_CYC = (DIV_CYC > MUL_CYC) ? DIV_CYC : MUL_CYC;
    localparam int CW      = ($clog2(MAX_CYC + 1) > 4) ? $clog2(MAX_CYC + 1) : 4;
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYC);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYC);

    logic [4:0]    r_dst_e;
    logic [4:0]    r_dst_m;
    logic [1:0]    r_tnew_e;
    logic [1:0]    r_tnew_m;
    logic          r_md_e;
    logic          r_md_div_e;
    logic [CW-1:0] r_cnt;

    logic [4:0] w_d_dst;
    logic [1:0] w_d_tnew;
    logic       w_rs_used;
    logic       w_rt_used;
    logic [1:0] w_tuse_rs;
    logic [1:0] w_tuse_rt;
    logic       w_rs_hz;
    logic       w_rt_hz;
    logic       w_stall_reg;
    logic       w_stall_md;
    logic       w_md_busy;
    logic       w_stall;
    logic [1:0] w_tnew_e_dec;

    always_comb begin
        w_d_dst = 5'd0;
        if (d_jal || d_r)      w_d_dst = d_rd;
        else if (d_i || d_ld)  w_d_dst = d_rt;

        w_d_tnew = 2'd0;
        if (d_ld)             w_d_tnew = 2'd2;
        else if (d_r || d_i)  w_d_tnew = 2'd1;

        w_rs_used = d_j | d_r | d_i | d_ld | d_st;
        w_tuse_rs = d_j ? 2'd0 : 2'd1;
        w_rt_used = d_j | d_r | d_st;
        w_tuse_rt = d_j ? 2'd0 : (d_r ? 2'd1 : 2'd2);
    end

    // A register 0 source never matches, so dst 0 (bubble/none) is never a hazard.
    always_comb begin
        w_rs_hz = w_rs_used && (d_rs != 5'd0) &&
                  (((d_rs == r_dst_e) && (w_tuse_rs < r_tnew_e)) ||
                   ((d_rs == r_dst_m) && (w_tuse_rs < r_tnew_m)));
        w_rt_hz = w_rt_used && (d_rt != 5'd0) &&
                  (((d_rt == r_dst_e) && (w_tuse_rt < r_tnew_e)) ||
                   ((d_rt == r_dst_m) && (w_tuse_rt < r_tnew_m)));
    end

    assign w_stall_reg  = w_rs_hz | w_rt_hz;
    assign w_md_busy    = r_md_e | (r_cnt != '0);
    assign w_stall_md   = d_md_use & w_md_busy;
    assign w_stall      = (w_stall_reg | w_stall_md) & ~clr;
    assign w_tnew_e_dec = (r_tnew_e == 2'd0) ? 2'd0 : (r_tnew_e - 2'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dst_e    <= 5'd0;
            r_dst_m    <= 5'd0;
            r_tnew_e   <= 2'd0;
            r_tnew_m   <= 2'd0;
            r_md_e     <= 1'b0;
            r_md_div_e <= 1'b0;
        end else if (clr) begin
            r_dst_e    <= 5'd0;
            r_dst_m    <= 5'd0;
            r_tnew_e   <= 2'd0;
            r_tnew_m   <= 2'd0;
            r_md_e     <= 1'b0;
            r_md_div_e <= 1'b0;
        end else begin
            r_dst_m  <= r_dst_e;
            r_tnew_m <= w_tnew_e_dec;
            if (w_stall) begin
                r_dst_e    <= 5'd0;
                r_tnew_e   <= 2'd0;
                r_md_e     <= 1'b0;
                r_md_div_e <= 1'b0;
            end else begin
                r_dst_e    <= w_d_dst;
                r_tnew_e   <= w_d_tnew;
                r_md_e     <= d_md_start;
                r_md_div_e <= d_md_start & d_md_div;
            end
        end
    end

    // Counter is only loaded from an op leaving E; a flush of that op skips the load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_md_e && !clr) begin
            r_cnt <= r_md_div_e ? DIV_LD : MUL_LD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign stall     = w_stall;
    assign stall_reg = w_stall_reg;
    assign stall_md  = w_stall_md;
    assign md_busy   = w_md_busy;
    assign dst_e     = r_dst_e;
    assign dst_m     = r_dst_m;

endmodule
